color_mixer_pwm: RTL and testbench

- Next-generation RGB color mixer: one push button steps through a color index; each of R/G/B is driven by an N-bit PWM, not a static on/off level.
- Adds input synchronisation, button debounce, a parametrised color count, a global brightness input, and glitch-free updates aligned to the PWM period.
- Sits between board I/O (SW2, LED_R/G/B) and the top level; one instance per RGB LED.

---
 rtl/color_mixer_pwm.sv | 182 ++++++++++++++++++
 tb/tb_color_mixer_pwm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/color_mixer_pwm.sv
// color_mixer_pwm
// ---------------------------------------------------------------------------
// RGB color mixer for one RGB LED. A push button steps through a color index.
// Each of red, green and blue is driven by a PWM output whose duty is the
// global brightness when the corresponding index bit is set, otherwise zero.
// Duty updates are applied only at the PWM period boundary, so a pulse that
// is already in progress is never cut short or stretched.
//
// Ports:
//   CLK          single system clock
//   RST_N        synchronous active-low reset
//   SW2          raw asynchronous push button, active-high
//   BRIGHT       global duty level applied to lit channels (PWM_BITS wide)
//   LED_R/G/B    PWM outputs, active-high, registered (lag the counter by 1)
//   COLOR_IDX    current color index; bit0 = R, bit1 = G, bit2 = B
//   PERIOD_START high in every cycle in which the PWM counter is 0
//
// Parameters:
//   PWM_BITS         PWM counter / brightness width, period = 2^PWM_BITS
//   DEBOUNCE_CYCLES  stable cycles needed for the button to change (1..65535)
//   NUM_COLORS       number of color indices (2..8)
//
// Build option:
//   COLOR_MIXER_FADE_EN  when defined, each applied duty steps one LSB toward
//                        its target per period instead of jumping to it.
// ---------------------------------------------------------------------------
module color_mixer_pwm #(
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_COLORS      = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                SW2,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B,
  output logic [2:0]          COLOR_IDX,
  output logic                PERIOD_START
);

  localparam logic [15:0]         DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]          IDX_LAST = 3'(NUM_COLORS - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  // -------------------------------------------------------------------------
  // Button synchroniser
  // -------------------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic sw_s;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= SW2;
      sync2_reg <= sync1_reg;
    end
  end

  assign sw_s = sync2_reg;

  // -------------------------------------------------------------------------
  // Debounce: count consecutive cycles in which the synchronised input
  // disagrees with the accepted state; any agreement restarts the count.
  // -------------------------------------------------------------------------
  logic        db_reg;
  logic        db_prev_reg;
  logic [15:0] db_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      db_reg      <= 1'b0;
      db_prev_reg <= 1'b0;
      db_cnt_reg  <= '0;
    end else begin
      db_prev_reg <= db_reg;
      if (sw_s != db_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_reg     <= sw_s;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 16'd1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Color index: advance one cycle after the debounced state rises.
  // -------------------------------------------------------------------------
  logic       press;
  logic [2:0] idx_reg;

  assign press = db_reg & ~db_prev_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx_reg <= '0;
    end else if (press) begin
      if (idx_reg == IDX_LAST) begin
        idx_reg <= '0;
      end else begin
        idx_reg <= idx_reg + 3'd1;
      end
    end
  end

  assign COLOR_IDX = idx_reg;

  // -------------------------------------------------------------------------
  // Free-running PWM counter
  // -------------------------------------------------------------------------
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                period_end;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  assign period_end = (pwm_cnt_reg == CNT_LAST);

  // The counter sits at 0 while reset is held, so the pulse is gated with
  // RST_N to keep it low during reset.
  assign PERIOD_START = RST_N & (pwm_cnt_reg == '0);

  // -------------------------------------------------------------------------
  // Per-channel duty and output. The applied duty is only updated on the
  // last count of a period, so it takes effect from count 0 of the next.
  // -------------------------------------------------------------------------
  logic [2:0] led_vec;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] duty_next;
    logic                led_reg;

    assign target = idx_reg[gi] ? BRIGHT : '0;

`ifdef COLOR_MIXER_FADE_EN
    always_comb begin
      duty_next = duty_reg;
      if (duty_reg < target) begin
        duty_next = duty_reg + PWM_BITS'(1);
      end else if (duty_reg > target) begin
        duty_next = duty_reg - PWM_BITS'(1);
      end
    end
`else
    assign duty_next = target;
`endif

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        duty_reg <= '0;
        led_reg  <= 1'b0;
      end else begin
        if (period_end) begin
          duty_reg <= duty_next;
        end
        led_reg <= (pwm_cnt_reg < duty_reg);
      end
    end

    assign led_vec[gi] = led_reg;
  end

  assign LED_R = led_vec[0];
  assign LED_G = led_vec[1];
  assign LED_B = led_vec[2];

endmodule

// File: tb/tb_color_mixer_pwm.sv
// Directed testbench for color_mixer_pwm (PWM_BITS=4, DEBOUNCE_CYCLES=4,
// NUM_COLORS=8). Outputs are sampled on the falling clock edge.
module tb_color_mixer_pwm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SW2;
  logic [3:0] BRIGHT;
  logic       LED_R;
  logic       LED_G;
  logic       LED_B;
  logic [2:0] COLOR_IDX;
  logic       PERIOD_START;

  int total = 0;
  int bad   = 0;

  color_mixer_pwm #(
    .PWM_BITS        (4),
    .DEBOUNCE_CYCLES (4),
    .NUM_COLORS      (8)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .SW2          (SW2),
    .BRIGHT       (BRIGHT),
    .LED_R        (LED_R),
    .LED_G        (LED_G),
    .LED_B        (LED_B),
    .COLOR_IDX    (COLOR_IDX),
    .PERIOD_START (PERIOD_START)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance to the next cycle with PERIOD_START high (at least one cycle).
  task automatic wait_period();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!PERIOD_START && n < 40);
    if (!PERIOD_START) check("period_timeout", 0, 1);
  endtask

  // Count LED high cycles over the next full period, aligned to the
  // one-cycle output lag (counter values 1..15 then 0).
  task automatic measure(output int r, output int g, output int b,
                         output int diff);
    r = 0; g = 0; b = 0; diff = 0;
    wait_period();
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      r += int'(LED_R);
      g += int'(LED_G);
      b += int'(LED_B);
      if (LED_R != LED_G || LED_G != LED_B) diff++;
    end
  endtask

  task automatic press();
    SW2 = 1'b1;
    repeat (10) @(negedge CLK);
    SW2 = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    int r, g, b, diff;
    int first, pulses, noise, w;

    RST_N = 1'b0; SW2 = 1'b0; BRIGHT = 4'd8;

    // Reset held for 5 cycles
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("rst_idx", int'(COLOR_IDX), 0);
    check("rst_leds", int'({LED_B, LED_G, LED_R}), 0);
    check("rst_period_start", int'(PERIOD_START), 0);

    // Release: counter is 0 now, so this cycle is the first period start
    RST_N = 1'b1;
    #1;
    check("first_period_start", int'(PERIOD_START), 1);
    first = -1; pulses = 0; noise = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge CLK);
      if (PERIOD_START) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (LED_R || LED_G || LED_B || COLOR_IDX != 3'd0) noise++;
    end
    check("period_spacing", first, 16);
    check("period_pulses_48", pulses, 3);
    check("idle_noise", noise, 0);

    // Glitch of 3 cycles is rejected
    SW2 = 1'b1;
    repeat (3) @(negedge CLK);
    SW2 = 1'b0;
    repeat (10) @(negedge CLK);
    check("glitch_idx", int'(COLOR_IDX), 0);

    // Clean press: index changes exactly 7 cycles after the rise
    SW2 = 1'b1;
    repeat (6) @(negedge CLK);
    check("press_idx_at6", int'(COLOR_IDX), 0);
    @(negedge CLK);
    check("press_idx_at7", int'(COLOR_IDX), 1);
    repeat (3) @(negedge CLK);
    SW2 = 1'b0;
    repeat (10) @(negedge CLK);
    check("release_idx", int'(COLOR_IDX), 1);

    // Wrap through all colors; at index 7 all channels run 8/16 in phase
    for (int k = 2; k <= 8; k++) begin
      press();
      check($sformatf("wrap_idx_%0d", k), int'(COLOR_IDX), k % 8);
      if (k == 7) begin
        measure(r, g, b, diff);
        check("white_r", r, 8);
        check("white_g", g, 8);
        check("white_b", b, 8);
        check("white_phase", diff, 0);
      end
    end

    // Index 1 duty edges
    press();
    check("edge_idx", int'(COLOR_IDX), 1);
    BRIGHT = 4'd0;
    measure(r, g, b, diff);
    check("bright0_r", r, 0);
    BRIGHT = 4'd15;
    measure(r, g, b, diff);
    check("bright15_r", r, 15);
    check("bright15_g", g, 0);
    check("bright15_b", b, 0);

    // BRIGHT 15 -> 3 at count 5: this pulse stays 15, next one is 3
    wait_period();
    w = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i == 5) BRIGHT = 4'd3;
      w += int'(LED_R);
    end
    check("midchange_cur", w, 15);
    measure(r, g, b, diff);
    check("midchange_next", r, 3);

    // Reset in the middle of a pulse
    BRIGHT = 4'd15;
    wait_period();
    wait_period();
    repeat (5) @(negedge CLK);
    check("mid_led_r", int'(LED_R), 1);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_leds", int'({LED_B, LED_G, LED_R}), 0);
    check("midrst_idx", int'(COLOR_IDX), 0);
    RST_N = 1'b1;
    #1;
    check("restart_period_start", int'(PERIOD_START), 1);
    first = -1; noise = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (PERIOD_START && first < 0) first = i;
      if (LED_R || LED_G || LED_B) noise++;
    end
    check("restart_spacing", first, 16);
    check("restart_leds", noise, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
